// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed scan controller for an 8-digit seven-segment display.
//   A 32-bit display word is accepted over valid/ready into a shadow
//   register. It is copied to the live display register only on a frame
//   boundary, so a frame never mixes nibbles from two words. Each digit
//   slot starts with an anode-off guard interval to suppress ghosting.
//
//   Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN
//     When defined, slots above the most significant nonzero nibble stay
//     dark for the whole slot. Slot 0 is always shown.
//
// Parameters
//   REFRESH_DIV   clock cycles per digit slot (>= 2)
//   BLANK_CYCLES  guard cycles with anodes off at slot start (< REFRESH_DIV)
//   DIGITS        active digit slots (1..8)
//
// Ports
//   clk         system clock
//   rst         synchronous active-high reset
//   load_valid  load_data is valid
//   load_ready  block can accept a new word
//   load_data   display word; nibble k is shown on digit k
//   digit       nibble to the decoder (digit[3] -> decoder input a)
//   sel         digit index to the decoder (sel[2] -> s1)
//   an_en       1 = anode may light, 0 = all anodes forced off
//   frame_done  one-cycle pulse in the first cycle of slot 0

module seg7_scan_driver #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int DIGITS       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [31:0] load_data,
    output logic [3:0]  digit,
    output logic [2:0]  sel,
    output logic        an_en,
    output logic        frame_done
);

    localparam int            CW        = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
    localparam logic [2:0]    IDX_LAST  = 3'(DIGITS - 1);

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    idx, idx_nxt;
    logic [31:0]   disp, disp_nxt;
    logic [31:0]   shadow;
    logic          pending, pending_nxt;
    logic          slot_end, frame_end, accept;
    logic          lit, lit_nxt;
    state_t        state, state_nxt;

    always_comb begin
        slot_end  = (cnt == CNT_LAST);
        frame_end = slot_end && (idx == IDX_LAST);
        accept    = load_valid && load_ready;

        cnt_nxt = slot_end ? '0 : cnt + CW'(1);

        idx_nxt = idx;
        if (slot_end)
            idx_nxt = frame_end ? 3'd0 : idx + 3'd1;

        // The shadow word only moves to the display on a frame boundary.
        // A word accepted on that same edge stays pending for a full frame.
        disp_nxt    = disp;
        pending_nxt = pending;
        if (frame_end && pending) begin
            disp_nxt    = shadow;
            pending_nxt = 1'b0;
        end else if (accept) begin
            pending_nxt = 1'b1;
        end

        state_nxt = (cnt_nxt < BLANK_END) ? ST_BLANK : ST_SHOW;
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Highest nonzero displayed nibble of the word that will be live next
    // cycle; slot 0 is lit even for an all-zero word.
    logic [2:0] msd;
    always_comb begin
        msd = 3'd0;
        for (int k = 0; k < DIGITS; k++)
            if (disp_nxt[4*k +: 4] != 4'd0)
                msd = 3'(k);
        lit_nxt = (idx_nxt <= msd);
    end
`else
    always_comb lit_nxt = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            disp       <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            state      <= ST_BLANK;
            lit        <= 1'b0;
            frame_done <= 1'b0;
            load_ready <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            disp       <= disp_nxt;
            pending    <= pending_nxt;
            state      <= state_nxt;
            lit        <= lit_nxt;
            frame_done <= frame_end;
            // Registered copy of ~pending keeps rst off the output path.
            load_ready <= ~pending_nxt;
            if (accept)
                shadow <= load_data;
        end
    end

    // Pure decodes of flops.
    assign sel   = idx;
    assign digit = disp[{idx, 2'b00} +: 4];
    assign an_en = (state == ST_SHOW) && lit;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
//   Directed bench for seg7_scan_driver with REFRESH_DIV=4, BLANK_CYCLES=1,
//   DIGITS=8. Every cycle is compared against a small cycle model of the
//   scan position and display word; key points of each scenario also get
//   explicit hand-computed checks.

module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_data;
    logic [3:0]  digit;
    logic [2:0]  sel;
    logic        an_en;
    logic        frame_done;

    seg7_scan_driver #(
        .REFRESH_DIV  (4),
        .BLANK_CYCLES (1),
        .DIGITS       (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .digit      (digit),
        .sel        (sel),
        .an_en      (an_en),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    // Cycle model state
    int          m_cnt, m_idx;
    logic [31:0] m_disp, m_shadow;
    logic        m_pend, m_fd, m_ready;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miss_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_lit();
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        int msd = 0;
        for (int k = 0; k < 8; k++)
            if (((m_disp >> (4*k)) & 32'hF) != 0) msd = k;
        return (m_idx <= msd);
`else
        return 1'b1;
`endif
    endfunction

    // One clock: advance the model with the inputs seen at the edge, then
    // compare every output 1 time unit after the edge.
    task automatic tick();
        logic acc, fe;
        @(posedge clk);
        acc = load_valid && m_ready;
        fe  = (m_cnt == 3) && (m_idx == 7);
        if (rst) begin
            m_cnt = 0; m_idx = 0; m_disp = 0; m_shadow = 0;
            m_pend = 0; m_fd = 0; m_ready = 0;
        end else begin
            if (fe && m_pend) begin
                m_disp = m_shadow;
                m_pend = 0;
            end else if (acc) begin
                m_pend = 1;
            end
            if (acc) m_shadow = load_data;
            m_fd    = fe;
            m_cnt   = (m_cnt + 1) % 4;
            if (m_cnt == 0) m_idx = (m_idx + 1) % 8;
            m_ready = !m_pend;
        end
        #1;
        check("m_sel",   32'(sel),        32'(m_idx));
        check("m_digit", 32'(digit),      (m_disp >> (4*m_idx)) & 32'hF);
        check("m_an_en", 32'(an_en),      32'((m_cnt >= 1) && model_lit()));
        check("m_fd",    32'(frame_done), 32'(m_fd));
        check("m_ready", 32'(load_ready), 32'(m_ready));
    endtask

    task automatic wait_fd(input string tag);
        for (int i = 0; i < 80 && frame_done !== 1'b1; i++) tick();
        check(tag, 32'(frame_done), 32'd1);
    endtask

    initial begin
        int pulses, nz;
        rst = 1'b1; load_valid = 1'b0; load_data = '0;

        // 1. reset
        repeat (3) tick();
        check("rst_digit", 32'(digit), 0);
        check("rst_sel",   32'(sel), 0);
        check("rst_an",    32'(an_en), 0);
        check("rst_fd",    32'(frame_done), 0);
        check("rst_ready", 32'(load_ready), 0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", 32'(load_ready), 1);
        check("post_rst_an",    32'(an_en), 1);

        // 2. free-running scan: two frame pulses in 64 cycles
        pulses = 0;
        repeat (64) begin
            tick();
            if (frame_done === 1'b1) pulses++;
        end
        check("fd_pulses", 32'(pulses), 2);
        check("scan_sel", 32'(sel), 0);

        // 3. mid-frame load
        load_valid = 1'b1; load_data = 32'h1234_5678;
        tick();
        load_valid = 1'b0; load_data = 32'hDEAD_BEEF;
        check("load_ready_drop", 32'(load_ready), 0);
        wait_fd("load_fd");
        check("load_ready_back", 32'(load_ready), 1);
        for (int s = 0; s < 8; s++) begin
            check("load_digit", 32'(digit), 32'(8 - s));
            check("load_sel",   32'(sel), 32'(s));
            repeat (4) tick();
        end

        // 4. back-to-back loads
        load_valid = 1'b1; load_data = 32'hAAAA_AAAA;
        tick();
        load_data = 32'h5555_5555;
        check("b2b_wait", 32'(load_ready), 0);
        wait_fd("b2b_fd");
        check("b2b_ready", 32'(load_ready), 1);
        check("b2b_first", 32'(digit), 32'hA);
        tick();
        load_valid = 1'b0;
        check("b2b_taken", 32'(load_ready), 0);
        for (int s = 0; s < 8; s++) begin
            check("b2b_a", 32'(digit), 32'hA);
            repeat (4) tick();
        end
        for (int s = 0; s < 8; s++) begin
            check("b2b_5", 32'(digit), 32'h5);
            repeat (4) tick();
        end

        // 5. reset mid-frame with a pending word
        load_valid = 1'b1; load_data = 32'hCAFE_BABE;
        tick();
        load_valid = 1'b0;
        check("mid_pending", 32'(load_ready), 0);
        for (int i = 0; i < 64 && sel !== 3'd5; i++) tick();
        check("mid_at5", 32'(sel), 5);
        rst = 1'b1;
        tick();
        check("mid_sel",   32'(sel), 0);
        check("mid_digit", 32'(digit), 0);
        check("mid_an",    32'(an_en), 0);
        rst = 1'b0;
        nz = 0;
        repeat (80) begin
            tick();
            if (digit !== 4'd0) nz++;
        end
        check("mid_discard", 32'(nz), 0);

`ifdef SEG7_LEADING_ZERO_BLANK_EN
        // 6. leading-zero blanking
        load_valid = 1'b1; load_data = 32'h0000_0A30;
        tick();
        load_valid = 1'b0;
        wait_fd("lz_fd");
        for (int s = 0; s < 8; s++) begin
            check("lz_digit", 32'(digit), (s == 0) ? 0 : (s == 1) ? 3 : (s == 2) ? 32'hA : 0);
            check("lz_blank", 32'(an_en), 0);
            tick();
            check("lz_show", 32'(an_en), 32'(s < 3));
            repeat (3) tick();
        end
        load_valid = 1'b1; load_data = 32'h0;
        tick();
        load_valid = 1'b0;
        wait_fd("lz0_fd");
        for (int s = 0; s < 8; s++) begin
            tick();
            check("lz0_show", 32'(an_en), 32'(s == 0));
            check("lz0_digit", 32'(digit), 0);
            repeat (3) tick();
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
